// File: rtl/pos_onehot_pulser.sv
// pos_onehot_pulser
//   Turns a stream of bit positions (the code a priority encoder emits) back into
//   a one-hot vector, driven as a pulse of HOLD cycles. Consecutive pulses are
//   separated by GAP all-zero cycles. A one-entry input buffer lets a new
//   position be accepted while the current pulse is still being driven.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   in_pos is valid
//   in_ready   an in_pos can be accepted this cycle
//   in_pos     bit index to assert
//   onehot     registered pulse output, all-zero while not driving
//   out_valid  onehot carries a pulse
//   busy       a pulse or gap is in progress, or the buffer holds an entry
//   err        sticky: an out-of-range in_pos (>= W) was accepted
module pos_onehot_pulser #(
  parameter int unsigned W    = 8,
  parameter int unsigned PW   = $clog2(W),
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pos,
  output logic [W-1:0]  onehot,
  output logic          out_valid,
  output logic          busy,
  output logic          err
);

  localparam int unsigned   MAXC    = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned   CW      = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [PW:0]   W_LIM   = (PW + 1)'(W);
  localparam logic [W-1:0]  ONE     = W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] buf_pos_q;
  logic          buf_full_q;
  logic [W-1:0]  onehot_q;
  logic          out_valid_q;
  logic          err_q;

  logic cnt_zero;
  logic load;
  logic accept;
  logic pos_ok;

  // load: the FSM takes the buffered position this cycle. in_ready depends only
  // on state, so a full buffer being drained can be refilled in the same cycle.
  always_comb begin
    cnt_zero = (cnt_q == '0);
    load     = 1'b0;
    unique case (state_q)
      S_IDLE:  load = buf_full_q;
      S_DRIVE: load = cnt_zero && (GAP == 0) && buf_full_q;
      S_GAP:   load = cnt_zero && buf_full_q;
      default: load = 1'b0;
    endcase
  end

  assign in_ready = ~buf_full_q | load;
  assign accept   = in_valid & in_ready;
  // Only reachable when W is not a power of two.
  assign pos_ok   = ({1'b0, in_pos} < W_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_pos_q   <= '0;
      buf_full_q  <= 1'b0;
      onehot_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Buffer: a valid accept wins over a simultaneous load so the entry stays full.
      if (accept && pos_ok) begin
        buf_pos_q  <= in_pos;
        buf_full_q <= 1'b1;
      end else if (load) begin
        buf_full_q <= 1'b0;
      end
      if (accept && !pos_ok) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (load) begin
            onehot_q    <= ONE << buf_pos_q;
            out_valid_q <= 1'b1;
            cnt_q       <= HOLD_LD;
            state_q     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (GAP > 0) begin
            onehot_q    <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= GAP_LD;
            state_q     <= S_GAP;
          end else if (load) begin
            // Back-to-back pulse with no idle cycle in between.
            onehot_q <= ONE << buf_pos_q;
            cnt_q    <= HOLD_LD;
          end else begin
            onehot_q    <= '0;
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_GAP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (load) begin
            onehot_q    <= ONE << buf_pos_q;
            out_valid_q <= 1'b1;
            cnt_q       <= HOLD_LD;
            state_q     <= S_DRIVE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign onehot    = onehot_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE) | buf_full_q;
  assign err       = err_q;

endmodule
